tea_key_scanner: RTL

Brute-force key-range sequencer that sits directly upstream of the TEA decryption core. Given a 64-bit ciphertext block and an inclusive 48-bit key range, it launches one decryption per candidate key and samples the core's plaintext-match flag. It stops at the first matching key or when the range is exhausted, then reports the result to the host/control logic.

---
 rtl/tea_key_scanner.sv | 117 +++++++++++
 1 files changed

// File: rtl/tea_key_scanner.sv
// Brute-force key-range sequencer feeding the TEA decryption core: launches one
// decryption per candidate key and stops at the first match or the end of the range.
module tea_key_scanner #(
    parameter int WAIT_CYCLES = 34
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    input  logic        go,
    input  logic        abort,
    input  logic [63:0] cipher,
    input  logic [47:0] key_lo,
    input  logic [47:0] key_hi,
    output logic        dec_ena,
    output logic        dec_start,
    output logic [63:0] dec_data,
    output logic [47:0] dec_key,
    input  logic        dec_valid,
    output logic        busy,
    output logic        done,
    output logic        found,
    output logic [47:0] key_found,
    output logic [48:0] keys_tried
);
    localparam int CW = $clog2(WAIT_CYCLES);
    localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [CW-1:0] r_wait_cnt;
    logic [47:0]   r_cur_key;
    logic [47:0]   r_end_key;
    logic [63:0]   r_cipher;
    logic          r_found;
    logic [47:0]   r_key_found;
    logic [48:0]   r_keys_tried;
    logic          w_abort_ok;
    logic          w_last_key;

    assign w_abort_ok = abort && (r_state != S_IDLE);
    assign w_last_key = (r_cur_key == r_end_key);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (go) w_state_next = (key_lo > key_hi) ? S_DONE : S_LAUNCH;
            S_LAUNCH: w_state_next = S_WAIT;
            S_WAIT:   if (r_wait_cnt == WAIT_LAST) w_state_next = S_CHECK;
            S_CHECK:  w_state_next = (dec_valid || w_last_key) ? S_DONE : S_LAUNCH;
            S_DONE:   w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
        // abort overrides whatever the current state decided, including a CHECK hit
        if (w_abort_ok) w_state_next = S_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_wait_cnt   <= '0;
            r_cur_key    <= '0;
            r_end_key    <= '0;
            r_cipher     <= '0;
            r_found      <= 1'b0;
            r_key_found  <= '0;
            r_keys_tried <= '0;
        end else if (ena) begin
            r_state <= w_state_next;
            case (r_state)
                S_IDLE: begin
                    if (go) begin
                        r_cipher     <= cipher;
                        r_cur_key    <= key_lo;
                        r_end_key    <= key_hi;
                        r_found      <= 1'b0;
                        r_key_found  <= '0;
                        r_keys_tried <= '0;
                    end
                end
                S_LAUNCH: r_wait_cnt <= '0;
                S_WAIT:   r_wait_cnt <= r_wait_cnt + 1'b1;
                S_CHECK: begin
                    if (!abort) begin
                        r_keys_tried <= r_keys_tried + 49'd1;
                        if (dec_valid) begin
                            r_found     <= 1'b1;
                            r_key_found <= r_cur_key;
                        end else if (!w_last_key) begin
                            // the key stays put on the last candidate so the top of the range never wraps
                            r_cur_key <= r_cur_key + 48'd1;
                        end
                    end
                end
                default: ;
            endcase
            if (w_abort_ok) r_found <= 1'b0;
        end
    end

    assign dec_ena    = ena;
    assign dec_start  = (r_state == S_LAUNCH);
    assign dec_data   = r_cipher;
    assign dec_key    = r_cur_key;
    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_DONE);
    assign found      = r_found;
    assign key_found  = r_key_found;
    assign keys_tried = r_keys_tried;
endmodule
